// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings and default
// reset / interrupt vector addresses.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC0 = 2'd1,
        ST_EXEC1 = 2'd2
    } seqState_t;

    localparam int          DEF_ADDR_W     = 16;
    localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
    localparam logic [15:0] DEF_INT_VECTOR = 16'h0010;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, instruction memory and the decoder/datapath.
// master = sequencer side, slave = memory/decoder side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              fetch_req;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic [7:0]        inst;
    logic              cycle;
    logic              M;
    logic              J;
    logic              MC;
    logic              LJ;
    logic              LJR;
    logic              CLI;
    logic [ADDR_W-1:0] jump_target;
    logic              irq;
    logic [ADDR_W-1:0] link;
    logic              int_active;

    modport master (
        output mem_addr, fetch_req, inst, cycle, link, int_active,
        input  mem_rdata, mem_ready, M, J, MC, LJ, LJR, CLI, jump_target, irq
    );

    modport slave (
        input  mem_addr, fetch_req, inst, cycle, link, int_active,
        output mem_rdata, mem_ready, M, J, MC, LJ, LJR, CLI, jump_target, irq
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Opcode fetch + two-phase execute sequencer; owns PC, link register and interrupt entry.
// Latency: 2 clocks per 1-cycle instruction, 3 per 2-cycle instruction, plus memory waits.
// Backpressure: FETCH holds until mem_ready; EXEC1 with M holds until mem_ready.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(DEF_INT_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);

    seqState_t         state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic [ADDR_W-1:0] linkReg, linkNext;
    logic [7:0]        instReg, instNext;
    logic              intActive, intNext;
    logic              retire;
    logic              cliNow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            linkReg   <= '0;
            instReg   <= 8'h00;
            intActive <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            linkReg   <= linkNext;
            instReg   <= instNext;
            intActive <= intNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        linkNext  = linkReg;
        instNext  = instReg;
        intNext   = intActive;
        retire    = 1'b0;
        cliNow    = 1'b0;

        case (state)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    instNext  = bus.mem_rdata;
                    pcNext    = pc + ADDR_W'(1);
                    stateNext = ST_EXEC0;
                end
            end
            ST_EXEC0: begin
                if (bus.MC) begin
                    stateNext = ST_EXEC1;
                end else begin
                    retire = 1'b1;
                    if (bus.LJ) begin
                        if (bus.LJR) begin
                            pcNext = linkReg;
                        end else begin
                            pcNext   = bus.jump_target;
                            linkNext = pc;
                        end
                        if (bus.CLI) begin
                            intNext = 1'b0;
                            cliNow  = 1'b1;
                        end
                    end
                end
            end
            ST_EXEC1: begin
                // The datapath owns the bus during a data access; wait for it.
                if (!(bus.M && !bus.mem_ready)) begin
                    retire = 1'b1;
                    if (bus.J) begin
                        pcNext = bus.jump_target;
                    end
                end
            end
            default: stateNext = ST_FETCH;
        endcase

        // Interrupt entry wins over any jump; the jump result is parked in link.
        if (retire) begin
            stateNext = ST_FETCH;
            if (bus.irq && !intActive && !cliNow) begin
                linkNext = pcNext;
                pcNext   = INT_VECTOR;
                intNext  = 1'b1;
            end
        end
    end

    assign bus.mem_addr   = pc;
    assign bus.fetch_req  = (state == ST_FETCH);
    assign bus.cycle      = (state == ST_EXEC1);
    assign bus.inst       = instReg;
    assign bus.link       = linkReg;
    assign bus.int_active = intActive;

endmodule
